// File: rtl/lms_update_unit_pkg.sv
// lms_update_unit_pkg: FSM states, default tap depth and the 32-bit saturation helper
package lms_update_unit_pkg;
   localparam int DEFAULT_MAX_TAPS = 16;
   typedef enum logic [2:0] {IDLE, COLLECT, ERROR, UPDATE, DONE} state_t;
   function automatic logic signed [31:0] sat32(input logic signed [64:0] v);
      return (v > 65'sd2147483647) ? 32'sh7fffffff : (v < -65'sd2147483648) ? 32'sh80000000 : v[31:0];
   endfunction
endpackage

// File: rtl/lms_update_unit_mac_sat.sv
// lms_mac_sat: w_new = sat32(w + floor(e*x / 2^MU_SHIFT)); ports w, e, x in, w_new out
module lms_mac_sat
   import lms_update_unit_pkg::*;
#(
   parameter int MU_SHIFT = 4
) (
   input  logic signed [31:0] w,
   input  logic signed [31:0] e,
   input  logic signed [31:0] x,
   output logic signed [31:0] w_new
);
   logic signed [63:0] prod;
   logic signed [64:0] sum;
   assign prod = 64'(e) * 64'(x);
   assign sum = 65'(w) + 65'(prod >>> MU_SHIFT);
   assign w_new = sat32(sum);
endmodule

// File: rtl/lms_update_unit.sv
// lms_update_unit: LMS weight updater; latches y/d, forms e = d - y, then streams updated weights
// ports: clk/rstn; tap_count; x, y, d sample streams; enable, clear;
//        coeff and error streams out; busy, update_done pulse, sticky x_overflow
module lms_update_unit
   import lms_update_unit_pkg::*;
#(
   parameter int MAX_TAPS = DEFAULT_MAX_TAPS,
   parameter int MU_SHIFT = 4
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [31:0]        tap_count,
   input  logic               x_data_valid,
   input  logic signed [31:0] x_data,
   input  logic               y_valid,
   input  logic signed [31:0] y_data,
   input  logic               d_valid,
   input  logic signed [31:0] d_data,
   input  logic               enable,
   input  logic               clear,
   output logic               coeff_data_valid,
   output logic signed [31:0] coeff_data,
   output logic               error_valid,
   output logic signed [31:0] error_data,
   output logic               busy,
   output logic               update_done,
   output logic               x_overflow
);
   localparam int KW = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
   localparam int CW = $clog2(MAX_TAPS + 1);
   state_t st, st_nx;
   logic signed [31:0] w [MAX_TAPS];
   logic signed [31:0] xh [MAX_TAPS];
   logic signed [31:0] xa [MAX_TAPS];
   logic signed [31:0] xb [MAX_TAPS];
   logic signed [31:0] y_lat, d_lat, e_reg, x_pend, y_nx, d_nx, w_new;
   logic signed [64:0] diff;
   logic y_have, d_have, pend_v, ovf, y_acc, d_acc, open_st, start;
   logic [KW-1:0] k, last;
   logic [CW-1:0] ne, ne_in;
   assign open_st = (st == IDLE) || (st == COLLECT);
   assign y_acc = enable && y_valid && open_st;
   assign d_acc = enable && d_valid && open_st;
   assign start = open_st && (y_acc || y_have) && (d_acc || d_have);
   assign y_nx = y_acc ? y_data : y_lat;
   assign d_nx = d_acc ? d_data : d_lat;
   assign diff = 65'(d_nx) - 65'(y_nx);
   assign ne_in = (tap_count == 0) ? CW'(1) : (tap_count > MAX_TAPS) ? CW'(MAX_TAPS) : tap_count[CW-1:0];
   assign last = KW'(ne - CW'(1));
   assign busy = (st == ERROR) || (st == UPDATE) || (st == DONE);
   lms_mac_sat #(.MU_SHIFT(MU_SHIFT)) u_mac (.w(w[k]), .e(e_reg), .x(xh[k]), .w_new(w_new));
   always_comb begin
      st_nx = st;
      case (st)
         IDLE, COLLECT: st_nx = start ? ERROR : (y_acc || d_acc) ? COLLECT : st;
         ERROR:         st_nx = UPDATE;
         UPDATE:        st_nx = (k == last) ? DONE : UPDATE;
         default:       st_nx = IDLE;
      endcase
      if (clear) st_nx = IDLE;
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) st <= IDLE;
      else st <= st_nx;
   // a pending sample (older) and a fresh one (newer) may both enter in the same idle cycle
   always_comb begin
      xa = xh;
      if (pend_v) begin
         for (int i = MAX_TAPS - 1; i > 0; i--) xa[i] = xh[i-1];
         xa[0] = x_pend;
      end
      xb = xa;
      if (x_data_valid) begin
         for (int i = MAX_TAPS - 1; i > 0; i--) xb[i] = xa[i-1];
         xb[0] = x_data;
      end
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < MAX_TAPS; i++) begin
            w[i] <= '0;
            xh[i] <= '0;
         end
         {y_lat, d_lat, e_reg, x_pend} <= '0;
         {y_have, d_have, pend_v, ovf} <= '0;
         k <= '0;
         ne <= CW'(1);
      end else if (clear) begin
         for (int i = 0; i < MAX_TAPS; i++) begin
            w[i] <= '0;
            xh[i] <= '0;
         end
         x_pend <= '0;
         {y_have, d_have, pend_v, ovf} <= '0;
         k <= '0;
      end else begin
         if (y_acc) y_lat <= y_data;
         if (d_acc) d_lat <= d_data;
         y_have <= !start && (y_have || y_acc);
         d_have <= !start && (d_have || d_acc);
         if (start) begin
            e_reg <= sat32(diff);
            ne <= ne_in;
         end
         k <= (st == UPDATE) ? k + KW'(1) : '0;
         if (st == UPDATE) w[k] <= w_new;
         if (busy) begin
            if (x_data_valid) begin
               if (pend_v) ovf <= 1'b1;
               else begin
                  x_pend <= x_data;
                  pend_v <= 1'b1;
               end
            end
         end else begin
            xh <= xb;
            pend_v <= 1'b0;
         end
      end
   end
   assign coeff_data_valid = (st == UPDATE) && !clear;
   assign coeff_data = coeff_data_valid ? w_new : '0;
   assign error_valid = (st == ERROR) && !clear;
   assign error_data = e_reg;
   assign update_done = (st == DONE) && !clear;
   assign x_overflow = ovf;
endmodule

// File: tb/tb_lms_update_unit.sv
// tb_lms_update_unit: randomized scoreboard bench for lms_update_unit against an arithmetic LMS model
module tb_lms_update_unit;
   localparam int MT = 16;
   localparam int MU = 4;
   localparam longint SMAX = 64'sh7fffffff;
   localparam longint SMIN = -64'sh80000000;
   logic clk = 1'b0, rstn = 1'b0;
   logic [31:0] tap_count;
   logic x_data_valid, y_valid, d_valid, enable, clear;
   logic signed [31:0] x_data, y_data, d_data;
   logic coeff_data_valid, error_valid, busy, update_done, x_overflow;
   logic signed [31:0] coeff_data, error_data;
   always #5 clk = ~clk;
   lms_update_unit #(.MAX_TAPS(MT), .MU_SHIFT(MU)) dut (
      .clk(clk), .rstn(rstn), .tap_count(tap_count),
      .x_data_valid(x_data_valid), .x_data(x_data),
      .y_valid(y_valid), .y_data(y_data), .d_valid(d_valid), .d_data(d_data),
      .enable(enable), .clear(clear),
      .coeff_data_valid(coeff_data_valid), .coeff_data(coeff_data),
      .error_valid(error_valid), .error_data(error_data),
      .busy(busy), .update_done(update_done), .x_overflow(x_overflow)
   );
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   typedef struct {int kind; int cyc; longint data;} ev_t;
   ev_t sb[$];
   int n_chk = 0, n_pass = 0;
   longint wm [MT];
   longint xm [MT];
   longint pend_m;
   bit pend_vm, ovf_m;
   task automatic chk(string nm, longint act, longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask
   function automatic longint sat(longint v);
      return v > SMAX ? SMAX : v < SMIN ? SMIN : v;
   endfunction
   function automatic longint floor_div(longint p);
      longint dv = longint'(1) << MU;
      longint q = p / dv;
      if (p < 0 && q * dv != p) q--;
      return q;
   endfunction
   function automatic void x_push(longint v);
      for (int i = MT - 1; i > 0; i--) xm[i] = xm[i-1];
      xm[0] = v;
   endfunction
   function automatic void zero_model();
      for (int i = 0; i < MT; i++) begin
         wm[i] = 0;
         xm[i] = 0;
      end
      pend_vm = 0;
      ovf_m = 0;
   endfunction
   function automatic int eff_taps(int unsigned tap);
      return tap == 0 ? 1 : tap > MT ? MT : int'(tap);
   endfunction
   function automatic void predict(int c, longint y, longint d, int unsigned tap, int cut);
      longint e = sat(d - y);
      int ne = eff_taps(tap);
      int lim = cut > 0 ? c + cut : 32'h7fffffff;
      if (c + 1 < lim) sb.push_back('{0, c + 1, e});
      for (int k = 0; k < ne; k++) begin
         wm[k] = sat(wm[k] + floor_div(e * xm[k]));
         if (c + 2 + k < lim) sb.push_back('{1, c + 2 + k, wm[k]});
      end
      if (c + 2 + ne < lim) sb.push_back('{2, c + 2 + ne, 0});
   endfunction
   function automatic int rnd_val();
      return $urandom_range(0, 3) == 0 ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
      y_valid = 0;
      d_valid = 0;
      x_data_valid = 0;
   endtask
   task automatic send_x(int v);
      tick();
      x_data_valid = 1;
      x_data = v;
      x_push(v);
   endtask
   task automatic do_clear();
      tick();
      clear = 1;
      tick();
      clear = 0;
      zero_model();
   endtask
   task automatic chk_zero(string tag);
      chk({tag, " coeff_valid"}, coeff_data_valid, 0);
      chk({tag, " error_valid"}, error_valid, 0);
      chk({tag, " update_done"}, update_done, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " x_overflow"}, x_overflow, 0);
      chk({tag, " coeff_data"}, coeff_data, 0);
      chk({tag, " error_data"}, error_data, 0);
   endtask
   // mode 0: y and d together; 1: d then y three cycles later; 2: y, overwriting y, then d
   // cut_kind 1 pulses clear and 2 pulses rstn at cycle offset cut after the final operand
   task automatic do_update(int mode, int y, int d, int unsigned tap, bit busy_x, int cut_kind, int cut);
      int c, ne, v;
      ne = eff_taps(tap);
      tick();
      if (mode == 1) begin
         d_valid = 1;
         d_data = d;
         tick();
         tick();
         if ($urandom_range(0, 1) == 1) begin
            v = rnd_val();
            x_data_valid = 1;
            x_data = v;
            x_push(v);
         end
         tick();
         y_valid = 1;
         y_data = y;
      end else if (mode == 2) begin
         y_valid = 1;
         y_data = rnd_val();
         tick();
         y_valid = 1;
         y_data = y;
         tick();
         d_valid = 1;
         d_data = d;
      end else begin
         y_valid = 1;
         y_data = y;
         d_valid = 1;
         d_data = d;
      end
      tap_count = tap;
      c = cyc;
      predict(c, y, d, tap, cut_kind != 0 ? cut : 0);
      for (int off = 1; off <= ne + 3; off++) begin
         tick();
         if (!rstn) rstn = 1;
         tap_count = $urandom_range(0, 40);
         clear = (cut_kind == 1 && off == cut);
         if (busy_x && (off == 2 || off == 3)) begin
            v = rnd_val();
            x_data_valid = 1;
            x_data = v;
            if (pend_vm) ovf_m = 1;
            else begin
               pend_vm = 1;
               pend_m = v;
            end
         end
         if (cut_kind == 2 && off == cut) begin
            rstn = 0;
            #1;
            chk_zero("abort");
            zero_model();
         end
         if (cut_kind == 0 && off == 1) chk("busy in error", busy, 1);
         if (off == ne + 3) chk("busy back in idle", busy, 0);
      end
      clear = 0;
      if (cut_kind != 0) zero_model();
      else if (pend_vm) begin
         x_push(pend_m);
         pend_vm = 0;
      end
      chk("x_overflow", x_overflow, ovf_m);
   endtask
   int mk;
   longint md;
   ev_t ev;
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         n_chk++;
         $display("FAIL missing event kind %0d: nothing seen, expected at cycle %0d", sb[0].kind, sb[0].cyc);
         void'(sb.pop_front());
      end
      if (coeff_data_valid || error_valid || update_done) begin
         mk = error_valid ? 0 : coeff_data_valid ? 1 : 2;
         md = error_valid ? longint'(error_data) : longint'(coeff_data);
         if (sb.size() == 0 || sb[0].cyc != cyc) begin
            n_chk++;
            $display("FAIL unexpected event kind %0d data %0d at cycle %0d, expected none", mk, md, cyc);
         end else begin
            ev = sb.pop_front();
            chk("event kind", mk, ev.kind);
            if (ev.kind == 0) chk("error_data", md, ev.data);
            if (ev.kind == 1) chk("coeff_data", md, ev.data);
         end
      end
   end
   initial begin
      {x_data_valid, y_valid, d_valid, clear} = '0;
      {x_data, y_data, d_data} = '0;
      enable = 1;
      tap_count = 2;
      zero_model();
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rstn = 1;
      send_x(32);
      send_x(16);
      do_update(0, 6, 10, 2, 0, 0, 0);
      do_clear();
      send_x(-700);
      send_x(300);
      do_update(1, 123, -45, 3, 0, 0, 0);
      do_clear();
      send_x(-700);
      send_x(300);
      do_update(0, 123, -45, 3, 0, 0, 0);
      do_clear();
      send_x(32'h7fffffff);
      do_update(0, -5, 32'h7fffffff, 1, 0, 0, 0);
      do_update(2, 1, int'(32'h80000000), 1, 0, 0, 0);
      for (int i = 0; i < 18; i++) send_x(rnd_val());
      do_update(0, rnd_val(), rnd_val(), 0, 0, 0, 0);
      do_update(0, rnd_val(), rnd_val(), 40, 0, 0, 0);
      do_update(0, rnd_val(), rnd_val(), 5, 1, 0, 0);
      do_clear();
      chk("x_overflow after clear", x_overflow, ovf_m);
      tick();
      enable = 0;
      y_valid = 1;
      d_valid = 1;
      y_data = 77;
      d_data = 99;
      tick();
      enable = 1;
      send_x(500);
      do_update(1, 20, 300, 2, 0, 0, 0);
      do_update(2, 30, -300, 2, 0, 0, 0);
      for (int i = 0; i < 4; i++) send_x(rnd_val());
      do_update(0, rnd_val(), rnd_val(), 8, 0, 1, 4);
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 3)) send_x(rnd_val());
         if ($urandom_range(0, 9) == 0) do_clear();
         do_update($urandom_range(0, 2), rnd_val(), rnd_val(), $urandom_range(0, 20),
                   $urandom_range(0, 4) == 0, 0, 0);
      end
      for (int i = 0; i < 6; i++) send_x(rnd_val());
      do_update(0, rnd_val(), rnd_val(), 16, 0, 2, 5);
      for (int i = 0; i < 3; i++) send_x(rnd_val());
      do_update(0, rnd_val(), rnd_val(), 4, 0, 0, 0);
      repeat (5) tick();
      while (sb.size() > 0) begin
         n_chk++;
         $display("FAIL leftover event kind %0d: never seen, expected at cycle %0d", sb[0].kind, sb[0].cyc);
         void'(sb.pop_front());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/lms_update_unit.md
LMS_UPDATE_UNIT -- requirements
Module: lms_update_unit

Interface
REQ-001 SHALL have parameter MAX_TAPS, default 16, the maximum number of weights held.
REQ-002 SHALL have parameter MU_SHIFT, default 4, the step size mu = 2^-MU_SHIFT.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port tap_count, input, 32 bits: number of active taps N.
REQ-006 SHALL have ports x_data_valid (input, 1 bit) and x_data (input, signed 32 bits): new input sample, same stream as the FIR datapath input.
REQ-007 SHALL have ports y_valid (input, 1 bit) and y_data (input, signed 32 bits): FIR output sample.
REQ-008 SHALL have ports d_valid (input, 1 bit) and d_data (input, signed 32 bits): desired sample.
REQ-009 SHALL have port enable, input, 1 bit: when low, y and d are ignored and no update starts.
REQ-010 SHALL have port clear, input, 1 bit: synchronous zeroing of the weights and the x history.
REQ-011 SHALL have ports coeff_data_valid (output, 1 bit) and coeff_data (output, signed 32 bits): updated weight stream to the FIR datapath.
REQ-012 SHALL have ports error_valid (output, 1 bit) and error_data (output, signed 32 bits): e = d - y.
REQ-013 SHALL have outputs busy (1 bit), update_done (1 bit, one-cycle pulse) and x_overflow (1 bit, sticky).

Function
REQ-014 SHALL hold an x history x[0..MAX_TAPS-1] (x[0] newest), shifted on every accepted x sample.
REQ-015 SHALL use effective tap count Ne = clamp(tap_count, 1, MAX_TAPS).
REQ-016 SHALL implement the FSM states IDLE, COLLECT, ERROR, UPDATE and DONE.
REQ-017 SHALL accept y and d in any order or in the same cycle in IDLE/COLLECT, latching each; a repeat valid before its pair is present SHALL overwrite the latched value.
REQ-018 SHALL move IDLE->COLLECT on the first accepted y or d, and move to ERROR in the cycle both are latched.
REQ-019 ERROR SHALL register e = sat32(d - y) and pulse error_valid for one cycle.
REQ-020 UPDATE SHALL process one tap per cycle for k = 0..Ne-1: w[k] = sat32(w[k] + (e*x[k] as a 64-bit product >>> MU_SHIFT)), with the arithmetic shift rounding toward minus infinity.
REQ-021 UPDATE SHALL drive coeff_data = the new w[k] with coeff_data_valid high in the same cycle, in ascending k.
REQ-022 Latency: with both operands latched at cycle t, error_valid SHALL assert at t+1, the first coeff at t+2, the last coeff at t+1+Ne, and update_done at t+2+Ne, after which the FSM returns to IDLE.
REQ-023 busy SHALL be high in the ERROR, UPDATE and DONE states.
REQ-024 An x sample arriving while busy SHALL be held in a one-entry pending register and shifted in during the cycle after DONE.
REQ-025 A second x sample arriving while one is already pending SHALL be dropped and SHALL set x_overflow until clear or reset.
REQ-026 clear SHALL abort any update, zero the weights, x history, pending entry and x_overflow, and return the FSM to IDLE; clear takes priority over every other input.
REQ-027 y and d asserting while busy SHALL be ignored.
REQ-028 tap_count SHALL be sampled on entry to ERROR; changes mid-update SHALL have no effect.

Reset
REQ-029 rstn low SHALL asynchronously force the FSM to IDLE and zero all weights, the x history, and the latched y, d and e.
REQ-030 During reset, coeff_data_valid, error_valid, update_done, busy and x_overflow SHALL all be 0.
REQ-031 During reset, coeff_data and error_data SHALL be 0.
REQ-032 Reset asserted mid-UPDATE SHALL discard the partial update with no further coeff output.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the sat32 saturation function and the default MAX_TAPS.
REQ-034 The block SHALL contain one sub-module, lms_mac_sat, a combinational multiply, shift, add and saturate stage.

Verification
REQ-035 Basic update: MU_SHIFT=4, tap_count=2, x history [16, 32], d=10, y=6 -> error_data=4, coeff stream 4 then 8, update_done at t+4.
REQ-036 Operand order: d arrives 3 cycles before y, then both in the same cycle -> identical e and coeff stream in each case.
REQ-037 Saturation: w0 = 0x7FFFFFF0, e = 1000, x0 = 1000, MU_SHIFT=0 -> coeff_data = 0x7FFFFFFF.
REQ-038 Clamp: tap_count=0 -> exactly 1 coeff; tap_count=40 -> exactly 16 coeffs.
REQ-039 Busy input: x pulses at t+2 and t+3 during UPDATE -> the first is applied after DONE, the second sets x_overflow.
REQ-040 Abort: rstn low mid-UPDATE -> all outputs 0 immediately; after release a fresh update uses weights of 0.
